// File: rtl/pwl_act_pipe_if.sv
// Stream bundle for the piecewise-linear activation pipe: input sample side and result side.
// The slave modport is the pipe's own view; the master modport is the producer/consumer view.
interface pwl_act_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAGW  = 4
);
    logic             i_valid;
    logic             i_ready;
    logic [WIDTH-1:0] i_data;
    logic             i_mode;
    logic [TAGW-1:0]  i_tag;
    logic             o_valid;
    logic             o_ready;
    logic [WIDTH-1:0] o_data;
    logic [TAGW-1:0]  o_tag;
    logic             o_sat;

    modport slave (
        input  i_valid, i_data, i_mode, i_tag, o_ready,
        output i_ready, o_valid, o_data, o_tag, o_sat
    );

    modport master (
        output i_valid, i_data, i_mode, i_tag, o_ready,
        input  i_ready, o_valid, o_data, o_tag, o_sat
    );
endinterface

// File: rtl/pwl_act_pipe.sv
// Piecewise-linear sigmoid/tanh (slopes 0, 1/8, 1/4) on signed Q(WIDTH-FRAC).FRAC data, tag passed through.
// Latency: 3 cycles, throughput 1 sample/cycle.
// Backpressure: a held result (o_valid & ~o_ready) freezes every stage and drops i_ready.
module pwl_act_pipe #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 20,
    parameter int TAGW  = 4
) (
    input logic           clk,
    input logic           rst,
    pwl_act_pipe_if.slave bus
);
    // Constants are formed in 64-bit so 16*2^FRAC cannot overflow before the divide.
    localparam longint ONE_L = longint'(1) << FRAC;

    localparam logic signed [WIDTH-1:0] ONE     = WIDTH'(ONE_L);
    localparam logic signed [WIDTH-1:0] HALF    = WIDTH'(ONE_L / 2);
    localparam logic signed [WIDTH-1:0] C04     = WIDTH'((2 * ONE_L) / 5);
    localparam logic signed [WIDTH-1:0] C06     = WIDTH'((3 * ONE_L) / 5);
    localparam logic signed [WIDTH-1:0] C08     = WIDTH'((4 * ONE_L) / 5);
    localparam logic signed [WIDTH-1:0] C32     = WIDTH'((16 * ONE_L) / 5);
    localparam logic signed [WIDTH-1:0] NEG_C08 = -C08;
    localparam logic signed [WIDTH-1:0] NEG_C32 = -C32;
    localparam logic signed [WIDTH-1:0] MAXV    = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MINV    = {1'b1, {(WIDTH-1){1'b0}}};

    typedef struct packed {
        logic                    valid;
        logic                    mode;
        logic [TAGW-1:0]         tag;
        logic                    sat;
        logic signed [WIDTH-1:0] val;
    } stage_t;

    stage_t s1_q, s1_d;
    stage_t s2_q, s2_d;
    stage_t s3_q, s3_d;

    logic                    en;
    logic signed [WIDTH-1:0] x_in;
    logic signed [WIDTH-1:0] xm;
    logic signed [WIDTH-1:0] xs;
    logic signed [WIDTH-1:0] s_sel;
    logic                    sat_sel;
    logic signed [WIDTH-1:0] sv;
    logic signed [WIDTH-1:0] y;

    assign en          = ~s3_q.valid | bus.o_ready;
    assign bus.i_ready = en;

    // Stage 1: tanh(x) = 2*sigmoid(2x) - 1, so tanh samples are pre-doubled with saturation.
    always_comb begin
        x_in = bus.i_data;
        if (bus.i_mode && (x_in[WIDTH-1] != x_in[WIDTH-2])) begin
            xm = x_in[WIDTH-1] ? MINV : MAXV;
        end else if (bus.i_mode) begin
            xm = x_in <<< 1;
        end else begin
            xm = x_in;
        end
        s1_d = s1_q;
        if (en) begin
            s1_d.valid = bus.i_valid;
            s1_d.mode  = bus.i_mode;
            s1_d.tag   = bus.i_tag;
            s1_d.sat   = 1'b0;
            s1_d.val   = xm;
        end
    end

    // Stage 2: region select and linear segment evaluation.
    always_comb begin
        xs      = s1_q.val;
        sat_sel = 1'b0;
        if (xs > C32) begin
            s_sel   = ONE;
            sat_sel = 1'b1;
        end else if (xs < NEG_C32) begin
            s_sel   = '0;
            sat_sel = 1'b1;
        end else if ((xs >= NEG_C08) && (xs <= C08)) begin
            s_sel = (xs >>> 2) + HALF;
        end else if (xs > C08) begin
            s_sel = (xs >>> 3) + C06;
        end else begin
            s_sel = (xs >>> 3) + C04;
        end
        s2_d = s2_q;
        if (en) begin
            s2_d     = s1_q;
            s2_d.val = s_sel;
            s2_d.sat = sat_sel;
        end
    end

    // Stage 3: s lies in 0..ONE, so 2s-ONE cannot wrap.
    always_comb begin
        sv = s2_q.val;
        y  = s2_q.mode ? ((sv <<< 1) - ONE) : sv;
        s3_d = s3_q;
        if (en) begin
            s3_d     = s2_q;
            s3_d.val = y;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign bus.o_valid = s3_q.valid;
    assign bus.o_data  = s3_q.val;
    assign bus.o_tag   = s3_q.tag;
    assign bus.o_sat   = s3_q.sat;
endmodule

// File: tb/tb_pwl_act_pipe.sv
// Bench for pwl_act_pipe: directed vectors with literal expectations plus a floor-arithmetic
// reference model feeding an in-order scoreboard checked on every output transfer.
module tb_pwl_act_pipe;
    localparam int W    = 32;
    localparam int F    = 20;
    localparam int TW   = 4;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic          sat;
        logic [W-1:0]  data;
    } exp_t;

    logic clk;
    logic rst;
    int   nchk;
    int   nerr;
    int   out_cnt;
    bit   rnd_en;
    bit   mon_stall;
    exp_t exp_q[$];

    logic [W-1:0] stream_x [8] = '{32'h00100000, 32'hFFE00000, 32'h00050000, 32'h7FFFFFFF,
                                   32'hFFF80000, 32'h00400000, 32'h000CCCCD, 32'h80000000};

    pwl_act_pipe_if #(.WIDTH(W), .TAGW(TW)) bus ();

    pwl_act_pipe #(.WIDTH(W), .FRAC(F), .TAGW(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        nchk++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic longint fdiv(input longint a, input longint b);
        return (a >= 0) ? (a / b) : -((-a + b - 1) / b);
    endfunction

    // Returns {sat, y}: plain integer evaluation of the activation definition.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic m);
        longint one, c04, c06, c08, c32, xv, xm, s, y;
        logic   sat;
        one = longint'(1) << F;
        c04 = (2 * one) / 5;
        c06 = (3 * one) / 5;
        c08 = (4 * one) / 5;
        c32 = (16 * one) / 5;
        xv  = longint'($signed(x));
        xm  = m ? 2 * xv : xv;
        if (xm > 64'sd2147483647)  xm = 64'sd2147483647;
        if (xm < -64'sd2147483648) xm = -64'sd2147483648;
        sat = 1'b0;
        if (xm > c32) begin
            s = one; sat = 1'b1;
        end else if (xm < -c32) begin
            s = 0; sat = 1'b1;
        end else if (xm >= -c08 && xm <= c08) begin
            s = fdiv(xm, 4) + one / 2;
        end else if (xm > 0) begin
            s = fdiv(xm, 8) + c06;
        end else begin
            s = fdiv(xm, 8) + c04;
        end
        y = m ? (2 * s - one) : s;
        return {sat, y[W-1:0]};
    endfunction

    always @(posedge rst) begin
        exp_q.delete();
        mon_stall = 1'b0;
    end

    // Scoreboard / protocol monitor, sampling on the falling edge.
    initial begin : mon
        logic [W-1:0]  pd;
        logic [TW-1:0] pt;
        logic          ps;
        logic [W:0]    r;
        exp_t          e;
        mon_stall = 1'b0;
        pd = '0; pt = '0; ps = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                mon_stall = 1'b0;
            end else begin
                chk("i_ready_rule", bus.i_ready, !bus.o_valid || bus.o_ready);
                if (mon_stall) begin
                    chk("stall_valid", bus.o_valid, 1);
                    chk("stall_data", bus.o_data, pd);
                    chk("stall_tag", bus.o_tag, pt);
                    chk("stall_sat", bus.o_sat, ps);
                end
                if (bus.o_valid && bus.o_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_o_valid", bus.o_valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_data", bus.o_data, e.data);
                        chk("sb_tag", bus.o_tag, e.tag);
                        chk("sb_sat", bus.o_sat, e.sat);
                        out_cnt++;
                    end
                end
                if (bus.i_valid && bus.i_ready) begin
                    r = model(bus.i_data, bus.i_mode);
                    e.tag  = bus.i_tag;
                    e.sat  = r[W];
                    e.data = r[W-1:0];
                    exp_q.push_back(e);
                end
                mon_stall = bus.o_valid && !bus.o_ready;
                pd = bus.o_data;
                pt = bus.o_tag;
                ps = bus.o_sat;
            end
        end
    end

    initial begin : ready_toggler
        forever begin
            @(posedge clk);
            #1;
            if (rnd_en) bus.o_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    task automatic run_one(input string name, input logic [W-1:0] x, input logic m,
                           input logic [TW-1:0] t, input logic [W-1:0] ed, input logic es);
        int k;
        @(posedge clk); #1;
        bus.i_valid = 1'b1; bus.i_data = x; bus.i_mode = m; bus.i_tag = t;
        @(negedge clk);
        chk({name, "_rdy"}, bus.i_ready, 1);
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.o_valid && k < 8);
        chk({name, "_lat"}, k, 3);
        chk({name, "_data"}, bus.o_data, ed);
        chk({name, "_tag"}, bus.o_tag, t);
        chk({name, "_sat"}, bus.o_sat, es);
    endtask

    initial begin : main
        int  n;
        bit  acc;
        nchk = 0; nerr = 0; out_cnt = 0; rnd_en = 1'b0;
        rst = 1'b1;
        bus.i_valid = 1'b0; bus.i_data = '0; bus.i_mode = 1'b0; bus.i_tag = '0;
        bus.o_ready = 1'b1;

        // Model pinned against hand-derived values.
        chk("model_x0", model(32'h0, 1'b0), {1'b0, 32'h00080000});
        chk("model_c32", model(32'h00333333, 1'b0), {1'b0, 32'h000FFFFF});
        chk("model_tanh_min", model(32'h80000000, 1'b1), {1'b1, 32'hFFF00000});

        // Reset and idle.
        #23;
        chk("rst_o_valid", bus.o_valid, 0);
        chk("rst_o_data", bus.o_data, 0);
        chk("rst_o_sat", bus.o_sat, 0);
        chk("rst_o_tag", bus.o_tag, 0);
        @(posedge clk); #3; rst = 1'b0;
        @(negedge clk);
        chk("rst_rel_i_ready", bus.i_ready, 1);

        // Sigmoid regions.
        run_one("sig_0",    32'h00000000, 1'b0, 4'd0, 32'h00080000, 1'b0);
        run_one("sig_p1",   32'h00100000, 1'b0, 4'd1, 32'h000B9999, 1'b0);
        run_one("sig_m1",   32'hFFF00000, 1'b0, 4'd2, 32'h00046666, 1'b0);
        run_one("sig_p4",   32'h00400000, 1'b0, 4'd3, 32'h00100000, 1'b1);
        run_one("sig_m4",   32'hFFC00000, 1'b0, 4'd4, 32'h00000000, 1'b1);
        // Region boundaries.
        run_one("sig_c08",  32'h000CCCCC, 1'b0, 4'd5, 32'h000B3333, 1'b0);
        run_one("sig_c08p", 32'h000CCCCD, 1'b0, 4'd6, 32'h000B3332, 1'b0);
        run_one("sig_c32",  32'h00333333, 1'b0, 4'd7, 32'h000FFFFF, 1'b0);
        run_one("sig_c32p", 32'h00333334, 1'b0, 4'd8, 32'h00100000, 1'b1);
        // Tanh.
        run_one("tanh_q",   32'h00040000, 1'b1, 4'd9,  32'h00040000, 1'b0);
        run_one("tanh_p3",  32'h00300000, 1'b1, 4'd10, 32'h00100000, 1'b1);
        run_one("tanh_max", 32'h7FFFFFFF, 1'b1, 4'd11, 32'h00100000, 1'b1);
        run_one("tanh_min", 32'h80000000, 1'b1, 4'd12, 32'hFFF00000, 1'b1);

        // Stalled saturated result, then asynchronous reset between edges.
        @(posedge clk); #1;
        bus.o_ready = 1'b0;
        bus.i_valid = 1'b1; bus.i_data = 32'h00400000; bus.i_mode = 1'b0; bus.i_tag = 4'd9;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        n = 0;
        while (!bus.o_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("hold_o_valid", bus.o_valid, 1);
        chk("hold_o_data", bus.o_data, 32'h00100000);
        chk("hold_o_sat", bus.o_sat, 1);
        @(negedge clk);
        chk("hold_i_ready", bus.i_ready, 0);
        #2; rst = 1'b1;
        #1;
        chk("arst_o_valid", bus.o_valid, 0);
        chk("arst_o_data", bus.o_data, 0);
        chk("arst_o_sat", bus.o_sat, 0);
        chk("arst_o_tag", bus.o_tag, 0);
        @(posedge clk); @(posedge clk); #3;
        rst = 1'b0; bus.o_ready = 1'b1;
        @(negedge clk);
        chk("arst_rel_i_ready", bus.i_ready, 1);

        // Reset with three samples in flight.
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            bus.i_valid = 1'b1; bus.i_data = stream_x[i]; bus.i_mode = 1'b0; bus.i_tag = 4'(i);
            @(posedge clk); #1;
        end
        bus.i_valid = 1'b0;
        #2; rst = 1'b1;
        @(posedge clk); @(posedge clk); #3; rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("midrst_idle_o_valid", bus.o_valid, 0);
        end
        run_one("midrst_new", 32'hFFF00000, 1'b0, 4'hA, 32'h00046666, 1'b0);

        // Backpressured stream with alternating modes.
        @(posedge clk); #1;
        out_cnt = 0;
        rnd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.i_valid = 1'b1; bus.i_data = stream_x[i]; bus.i_mode = i[0]; bus.i_tag = 4'(i);
            acc = 1'b0; n = 0;
            while (!acc && n < 200) begin
                @(negedge clk);
                acc = bus.i_ready;
                @(posedge clk); #1;
                n++;
            end
            if (!acc) chk("stream_accept", bus.i_ready, 1);
        end
        bus.i_valid = 1'b0;
        n = 0;
        while (out_cnt < 8 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("stream_out_count", out_cnt, 8);
        rnd_en = 1'b0;
        @(posedge clk); #2;
        bus.o_ready = 1'b1;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
